// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multicycle load/store initiator between the RV32I core datapath
// and the byte-addressed data memory.
//
// Ports:
//   clk, reset             clock; asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_ready is high only in IDLE
//   req_store              1 = store, 0 = load
//   req_funct3             RV32I funct3 of the access
//   req_base/req_offset    rs1 value and signed 12-bit immediate
//   req_wdata              rs2 value for stores
//   resp_valid             one-cycle result pulse
//   resp_data/addr/err     load result, effective address, error flag
//   mem_op/addr/wdata      single memory beat (mem_op is NON outside ISSUE)
//   mem_rdata              memory read data, registered by the memory
//   load_cnt/store_cnt     completed legal loads/stores (wrapping)
module lsu_ctrl #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h1300_0000,
    parameter bit          CHECK_ALIGN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [31:0] resp_addr,
    output logic        resp_err,
    output logic [3:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt
);

    // MEMOP_* encoding of control_op_def.v
    typedef enum logic [3:0] {
        MEMOP_NON = 4'd0,
        MEMOP_LB  = 4'd1,
        MEMOP_LH  = 4'd2,
        MEMOP_LW  = 4'd3,
        MEMOP_LBU = 4'd4,
        MEMOP_LHU = 4'd5,
        MEMOP_SB  = 4'd6,
        MEMOP_SH  = 4'd7,
        MEMOP_SW  = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    memop_e      mem_op_q;
    logic [31:0] eff_q;
    logic        err_q;
    logic        store_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic [31:0] resp_addr_q;
    logic        resp_err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;

    // Request decode (only meaningful at the accept edge)
    logic [31:0] eff;
    memop_e      dec_op;
    logic        dec_illegal;
    logic        dec_half;
    logic        dec_word;
    logic        dec_err;
    logic        accept;

    assign eff = req_base + {{20{req_offset[11]}}, req_offset};

    always_comb begin
        dec_op      = MEMOP_NON;
        dec_illegal = 1'b0;
        dec_half    = 1'b0;
        dec_word    = 1'b0;
        if (req_store) begin
            case (req_funct3)
                3'd0:    dec_op = MEMOP_SB;
                3'd1:    begin dec_op = MEMOP_SH; dec_half = 1'b1; end
                3'd2:    begin dec_op = MEMOP_SW; dec_word = 1'b1; end
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'd0:    dec_op = MEMOP_LB;
                3'd1:    begin dec_op = MEMOP_LH;  dec_half = 1'b1; end
                3'd2:    begin dec_op = MEMOP_LW;  dec_word = 1'b1; end
                3'd4:    dec_op = MEMOP_LBU;
                3'd5:    begin dec_op = MEMOP_LHU; dec_half = 1'b1; end
                default: dec_illegal = 1'b1;
            endcase
        end
        dec_err = dec_illegal
                | (CHECK_ALIGN && dec_half && eff[0])
                | (CHECK_ALIGN && dec_word && (eff[1:0] != 2'b00))
                | (req_store && (dec_half || dec_word) && (eff == CONSOLE_ADDR));
    end

    // Next-state logic. Rejected requests pass through WAIT (with no memory
    // op) so that the registered DONE outputs appear one cycle after accept.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = dec_err ? WAIT : ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_op_q     <= MEMOP_NON;
            eff_q        <= '0;
            err_q        <= 1'b0;
            store_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_addr_q  <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= (state_d == IDLE);
            resp_valid_q <= (state_d == DONE);
            mem_op_q     <= MEMOP_NON;

            if (accept) begin
                eff_q   <= eff;
                err_q   <= dec_err;
                store_q <= req_store;
                if (!dec_err) begin
                    mem_op_q    <= dec_op;
                    mem_addr_q  <= eff;
                    mem_wdata_q <= req_wdata;
                end
            end

            // WAIT -> DONE: memory data is valid now; publish the result.
            if (state_q == WAIT) begin
                resp_addr_q <= eff_q;
                resp_err_q  <= err_q;
                resp_data_q <= (!store_q && !err_q) ? mem_rdata : '0;
                if (!err_q) begin
                    if (store_q) store_cnt_q <= store_cnt_q + 32'd1;
                    else         load_cnt_q  <= load_cnt_q + 32'd1;
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_addr  = resp_addr_q;
    assign resp_err   = resp_err_q;
    assign mem_op     = mem_op_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_cnt   = load_cnt_q;
    assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam logic [3:0] NON = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3,
                           LBU = 4'd4, LHU = 4'd5, SB = 4'd6, SH = 4'd7,
                           SW = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_base = '0;
    logic [11:0] req_offset = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic        resp_err;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;

    lsu_ctrl #(.CONSOLE_ADDR(32'h1300_0000), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_addr(resp_addr), .resp_err(resp_err),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ops = 0;
    logic [3:0]  last_op = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] exp_loads = '0;
    logic [31:0] exp_stores = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0104) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
    endfunction

    // Memory: registers read data at the edge it samples a load op.
    always @(posedge clk)
        if (mem_op >= LB && mem_op <= LHU) mem_rdata <= mem_word(mem_addr);

    // Record every memory beat, sampled mid-cycle.
    always @(negedge clk)
        if (mem_op != NON) begin
            ops++;
            last_op    = mem_op;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [11:0] off;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] addr;
        logic [3:0]  op;
    } vec_t;

    vec_t vecs[12];

    task automatic run_req(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_store  = v.store;
        req_funct3 = v.f3;
        req_base   = v.base;
        req_offset = v.off;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        ops = 0;
        @(posedge clk);
        #1;
        // Scramble request inputs after acceptance; they must be ignored.
        req_valid  = 1'b0;
        req_base   = $urandom;
        req_offset = 12'($urandom);
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        req_store  = ~v.store;
        n = 0;
        while (n < 6) begin
            @(posedge clk);
            #1;
            n++;
            if (resp_valid) break;
        end
        chk("resp_latency", n, v.err ? 32'd1 : 32'd2);
        if (!v.err) begin
            if (v.store) exp_stores++; else exp_loads++;
        end
        chk("resp_err", {31'd0, resp_err}, {31'd0, v.err});
        chk("resp_addr", resp_addr, v.addr);
        chk("resp_data", resp_data,
            (v.err || v.store) ? 32'd0 : mem_word(v.addr));
        chk("load_cnt", load_cnt, exp_loads);
        chk("store_cnt", store_cnt, exp_stores);
        chk("mem_op_beats", ops, v.err ? 32'd0 : 32'd1);
        if (!v.err) begin
            chk("mem_op_code", {28'd0, last_op}, {28'd0, v.op});
            chk("mem_addr", last_addr, v.addr);
            if (v.store) chk("mem_wdata", last_wdata, v.wdata);
        end
        @(posedge clk);
        #1;
        chk("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
        chk("resp_addr_hold", resp_addr, v.addr);
    endtask

    initial begin
        int quiet;
        vecs[0]  = '{1'b0, 3'd2, 32'h0000_0100, 12'h004, 32'h0,         1'b0, 32'h0000_0104, LW};
        vecs[1]  = '{1'b1, 3'd0, 32'h1300_0000, 12'h000, 32'h0000_0041, 1'b0, 32'h1300_0000, SB};
        vecs[2]  = '{1'b1, 3'd2, 32'h1300_0000, 12'h000, 32'h1234_5678, 1'b1, 32'h1300_0000, NON};
        vecs[3]  = '{1'b0, 3'd2, 32'h0000_0100, 12'h002, 32'h0,         1'b1, 32'h0000_0102, NON};
        vecs[4]  = '{1'b0, 3'd0, 32'h0000_0000, 12'hFFF, 32'h0,         1'b0, 32'hFFFF_FFFF, LB};
        vecs[5]  = '{1'b0, 3'd3, 32'h0000_0200, 12'h000, 32'h0,         1'b1, 32'h0000_0200, NON};
        vecs[6]  = '{1'b0, 3'd1, 32'h0000_0201, 12'h000, 32'h0,         1'b1, 32'h0000_0201, NON};
        vecs[7]  = '{1'b0, 3'd5, 32'h0000_0200, 12'h7FE, 32'h0,         1'b0, 32'h0000_09FE, LHU};
        vecs[8]  = '{1'b1, 3'd1, 32'h0000_1000, 12'h800, 32'h0000_1234, 1'b0, 32'h0000_0800, SH};
        vecs[9]  = '{1'b1, 3'd4, 32'h0000_0300, 12'h000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0300, NON};
        vecs[10] = '{1'b0, 3'd4, 32'h1300_0000, 12'h000, 32'h0,         1'b0, 32'h1300_0000, LBU};
        vecs[11] = '{1'b1, 3'd0, 32'h0000_0000, 12'hFFC, 32'hA5A5_5A5A, 1'b0, 32'hFFFF_FFFC, SB};

        // Reset values
        #12;
        chk("rst_mem_op_in_reset", {28'd0, mem_op}, 32'd0);
        #5;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_addr", resp_addr, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_op", {28'd0, mem_op}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_cnt", load_cnt, 32'd0);
        chk("rst_store_cnt", store_cnt, 32'd0);

        for (int i = 0; i < 12; i++) run_req(vecs[i]);

        // Reset asserted while the memory beat is on the bus
        @(negedge clk);
        req_store = 1'b0; req_funct3 = 3'd2; req_base = 32'h100; req_offset = 12'h004;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("issue_mem_op", {28'd0, mem_op}, {28'd0, LW});
        #2;
        reset = 1'b0;
        #1;
        chk("abort_mem_op", {28'd0, mem_op}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_load_cnt", load_cnt, 32'd0);
        chk("abort_store_cnt", store_cnt, 32'd0);
        chk("abort_resp_addr", resp_addr, 32'd0);
        exp_loads = '0;
        exp_stores = '0;
        @(negedge clk);
        reset = 1'b1;
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid || mem_op != NON) quiet++;
        end
        chk("abort_no_activity", quiet, 32'd0);
        run_req(vecs[0]);
        run_req(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
